regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- s0_valid  in  1  ALU writeback request
- s0_rd  in  5  ALU destination register
- s0_data  in  32  ALU result
- s0_ready  out  1  ALU request accepted this cycle
- s1_valid  in  1  LSU writeback request
- s1_rd  in  5  LSU destination register
- s1_data  in  32  LSU load data
- s1_ready  out  1  LSU request accepted this cycle
- iss_valid  in  1  issue claims a destination register
- iss_rd  in  5  register claimed by issue
- iss_stall  out  1  claim refused this cycle
- q_addr1  in  5  scoreboard query, read port 1
- q_addr2  in  5  scoreboard query, read port 2
- q_busy1  out  1  q_addr1 has a pending write
- q_busy2  out  1  q_addr2 has a pending write
- flush  in  1  discard all pending claims
- we  out  1  register file write enable
- waddr  out  5  register file write address
- wdata  out  32  register file write data

Function
REQ-002 SHALL share the single register file write port between s0 and s1, accepting at most one request per cycle.
REQ-003 Grant rules:
- only one source valid: grant that source
- both valid: grant the source not granted most recently
- last-grant pointer SHALL update on every grant
REQ-004 s0_ready and s1_ready SHALL be combinational, one-hot or zero; a request is accepted when valid and ready are both high on a rising edge.
REQ-005 An unaccepted request SHALL hold valid, rd and data stable until accepted.
REQ-006 An accepted request with rd != 0 SHALL drive we=1 with waddr=rd and wdata=data in the next cycle (registered, latency 1).
REQ-007 An accepted request with rd == 0 SHALL be consumed; we SHALL be 0 in the next cycle.
REQ-008 we SHALL be 0 in any cycle following a cycle with no acceptance.
REQ-009 Scoreboard: SHALL keep 32 pending bits; bit 0 SHALL always read 0.
REQ-010 Claim: iss_valid=1, iss_rd != 0 and iss_stall=0 SHALL set pending[iss_rd] on the next edge.
REQ-011 iss_stall SHALL equal iss_valid AND pending[iss_rd] AND NOT (we AND waddr==iss_rd), combinationally.
REQ-012 A cycle with we=1 SHALL clear pending[waddr] on that cycle's edge.
REQ-013 Set and clear of the same bit on one edge: set SHALL win.
REQ-014 q_busyN SHALL equal pending[q_addrN] AND NOT (we AND waddr==q_addrN), combinationally, which matches register file write-to-read forwarding; q_addrN==0 SHALL give 0.
REQ-015 flush=1 SHALL clear all pending bits on the edge and override any same-cycle claim.
REQ-016 flush SHALL NOT cancel a write already registered on we, nor a request accepted in the same cycle.
REQ-017 Arbitration and grants SHALL be independent of the scoreboard and of flush.

Reset
REQ-018 rst_n low SHALL immediately force:
- we=0, waddr=0, wdata=0
- all pending bits 0
- last-grant pointer set so s0 wins the first contention
REQ-019 During reset, s0_ready, s1_ready, iss_stall, q_busy1 and q_busy2 SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL discard any accepted-but-unwritten request, with no write after release.

Verification
REQ-021 Run 1, single source: s0 {rd=5, data=0xDEADBEEF} -> s0_ready=1; next cycle we=1, waddr=5, wdata=0xDEADBEEF.
REQ-022 Run 2, contention: s0 and s1 held valid for 4 cycles after reset -> grants s0,s1,s0,s1; we=1 on each following cycle.
REQ-023 Run 3, scoreboard: claim rd=7 -> q_busy1(7)=1; second claim on rd=7 -> iss_stall=1; write to 7 -> q_busy1=0 in the we cycle; bit clears on that edge.
REQ-024 Run 4, x0 write: s1 {rd=0, data=0x1234} -> s1_ready=1; next cycle we=0; q_busy(0)=0 at all times.
REQ-025 Run 5, flush: claims on 3 and 9, then flush with a same-cycle claim on 4 -> all busy bits 0; a write already on we still completes.
REQ-026 Run 6, reset mid-operation: accept s0 {rd=2}, then pull rst_n low before the next edge -> we=0 immediately and stays 0 after release; pending bits all 0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between ALU (s0) and LSU (s1),
// and keeps a pending-write scoreboard that issue claims and writeback clears.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    input  logic [4:0]  s0_rd,
    input  logic [31:0] s0_data,
    output logic        s0_ready,
    input  logic        s1_valid,
    input  logic [4:0]  s1_rd,
    input  logic [31:0] s1_data,
    output logic        s1_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_stall,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy1,
    output logic        q_busy2,
    input  logic        flush,
    output logic        we,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    logic        last_s1;   // 1: s1 was granted most recently, so s0 wins the next tie
    logic [31:0] pending;
    logic [31:0] pend_nxt;
    logic        claim;

    assign s0_ready = rst_n & s0_valid & (~s1_valid | last_s1);
    assign s1_ready = rst_n & s1_valid & (~s0_valid | ~last_s1);

    // A write on the port this cycle is already visible to readers through forwarding
    assign iss_stall = rst_n & iss_valid & pending[iss_rd] & ~(we && waddr == iss_rd);
    assign q_busy1   = rst_n & pending[q_addr1] & ~(we && waddr == q_addr1);
    assign q_busy2   = rst_n & pending[q_addr2] & ~(we && waddr == q_addr2);

    assign claim = iss_valid && (iss_rd != 5'd0) && !iss_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_s1 <= 1'b1;
        end else if (s0_ready) begin
            last_s1 <= 1'b0;
        end else if (s1_ready) begin
            last_s1 <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we    <= 1'b0;
            waddr <= 5'd0;
            wdata <= 32'd0;
        end else begin
            we <= (s0_ready && s0_rd != 5'd0) || (s1_ready && s1_rd != 5'd0);
            if (s0_ready) begin
                waddr <= s0_rd;
                wdata <= s0_data;
            end else if (s1_ready) begin
                waddr <= s1_rd;
                wdata <= s1_data;
            end
        end
    end

    // Clear first, then set, so a same-edge claim wins; flush overrides both
    always_comb begin
        pend_nxt = pending;
        if (we)
            pend_nxt[waddr] = 1'b0;
        if (claim)
            pend_nxt[iss_rd] = 1'b1;
        if (flush)
            pend_nxt = '0;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pend_nxt;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed runs plus randomized traffic
// compared against a behavioural model of grants, writeback and scoreboard.
module tb_regfile_wb_arbiter;

    logic        clk, rst_n;
    logic        s0_valid, s1_valid, iss_valid, flush;
    logic [4:0]  s0_rd, s1_rd, iss_rd, q_addr1, q_addr2;
    logic [31:0] s0_data, s1_data;
    logic        s0_ready, s1_ready, iss_stall, q_busy1, q_busy2, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    // model state
    bit        m_pend [32];
    int        m_last;       // 0: s0 granted most recently, 1: s1
    bit        m_we;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;

    regfile_wb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_rd(s0_rd), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_rd(s1_rd), .s1_data(s1_data), .s1_ready(s1_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .flush(flush), .we(we), .waddr(waddr), .wdata(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit [1:0] model_grant();  // {s1, s0}
        if (s0_valid && s1_valid)
            return (m_last == 0) ? 2'b10 : 2'b01;
        return {s1_valid, s0_valid};
    endfunction

    function automatic bit exp_busy(input bit [4:0] a);
        return (a != 0) && m_pend[a] && !(m_we && m_waddr == a);
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last = 1; m_we = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic idle_inputs();
        s0_valid = 0; s0_rd = 0; s0_data = 0;
        s1_valid = 0; s1_rd = 0; s1_data = 0;
        iss_valid = 0; iss_rd = 0; flush = 0; q_addr1 = 0; q_addr2 = 0;
    endtask

    // advance one clock edge, updating the model from the inputs held before the edge
    task automatic tick();
        bit [1:0]  g;
        bit        n_we, stall;
        bit [4:0]  n_addr;
        bit [31:0] n_data;
        bit        n_pend [32];
        g = model_grant();
        stall = iss_valid && exp_busy(iss_rd);
        n_we = 0; n_addr = m_waddr; n_data = m_wdata;
        if (g[0]) begin n_we = (s0_rd != 0); n_addr = s0_rd; n_data = s0_data; end
        if (g[1]) begin n_we = (s1_rd != 0); n_addr = s1_rd; n_data = s1_data; end
        n_pend = m_pend;
        if (m_we) n_pend[m_waddr] = 0;
        if (iss_valid && iss_rd != 0 && !stall) n_pend[iss_rd] = 1;
        if (flush) foreach (n_pend[i]) n_pend[i] = 0;
        @(posedge clk);
        m_pend = n_pend; m_we = n_we; m_waddr = n_addr; m_wdata = n_data;
        if (g[0]) m_last = 0;
        if (g[1]) m_last = 1;
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk); rst_n = 0; #1;
        model_reset();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs();
        model_reset();
        s0_valid = 1; s1_valid = 1; iss_valid = 1; iss_rd = 6; q_addr1 = 6; q_addr2 = 1;
        #12;
        checks++;
        if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            errors++; $display("FAIL reset_wr: we=%b waddr=%0d wdata=%h, want 0/0/0", we, waddr, wdata);
        end
        checks++;
        if ({s0_ready, s1_ready, iss_stall, q_busy1, q_busy2} !== 5'b0) begin
            errors++; $display("FAIL reset_comb: rdy/stall/busy=%b, want 00000",
                               {s0_ready, s1_ready, iss_stall, q_busy1, q_busy2});
        end
        idle_inputs();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL reset_idle_we: got %b want 0", we); end
    endtask

    task automatic test_single();
        s0_valid = 1; s0_rd = 5; s0_data = 32'hDEADBEEF; #1;
        checks++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready: s0_ready=%b s1_ready=%b want 1/0", s0_ready, s1_ready);
        end
        tick(); idle_inputs();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_wb: we=%b waddr=%0d wdata=%h want 1/5/deadbeef", we, waddr, wdata);
        end
        tick();
        checks++;
        if (we !== 1'b0) begin errors++; $display("FAIL single_idle_we: got %b want 0", we); end
    endtask

    task automatic test_contention();
        bit [3:0] pat = 4'b1010; // bit i set: s1 wins grant i
        do_reset();
        s0_valid = 1; s0_rd = 1; s0_data = 32'hA0;
        s1_valid = 1; s1_rd = 17; s1_data = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (s0_ready !== !pat[i] || s1_ready !== pat[i]) begin
                errors++; $display("FAIL contend_grant%0d: s0_ready=%b s1_ready=%b want %b/%b",
                                   i, s0_ready, s1_ready, !pat[i], pat[i]);
            end
            tick();
            checks++;
            if (we !== 1'b1 || waddr !== (pat[i] ? s1_rd : s0_rd)) begin
                errors++; $display("FAIL contend_wb%0d: we=%b waddr=%0d want 1/%0d",
                                   i, we, waddr, pat[i] ? s1_rd : s0_rd);
            end
            if (pat[i]) begin s1_rd = s1_rd + 1; s1_data = s1_data + 1; end
            else        begin s0_rd = s0_rd + 1; s0_data = s0_data + 1; end
        end
        idle_inputs(); tick();
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 7; #1;
        checks++;
        if (iss_stall !== 1'b0) begin errors++; $display("FAIL sb_first_claim: stall=%b want 0", iss_stall); end
        tick(); iss_valid = 0; q_addr1 = 7; #1;
        checks++;
        if (q_busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy: q_busy1=%b want 1", q_busy1); end
        iss_valid = 1; #1;
        checks++;
        if (iss_stall !== 1'b1) begin errors++; $display("FAIL sb_second_claim: stall=%b want 1", iss_stall); end
        tick(); iss_valid = 0;
        s0_valid = 1; s0_rd = 7; s0_data = 32'h77;
        tick(); s0_valid = 0; #1;
        checks++;
        if (we !== 1'b1 || q_busy1 !== 1'b0) begin
            errors++; $display("FAIL sb_fwd: we=%b q_busy1=%b want 1/0", we, q_busy1);
        end
        tick();
        checks++;
        if (q_busy1 !== 1'b0 || we !== 1'b0) begin
            errors++; $display("FAIL sb_cleared: q_busy1=%b we=%b want 0/0", q_busy1, we);
        end
        // claim on the register being written this cycle: set beats clear
        iss_valid = 1; iss_rd = 7; tick(); iss_valid = 0;
        s0_valid = 1; s0_rd = 7; tick(); s0_valid = 0;
        iss_valid = 1; #1;
        checks++;
        if (iss_stall !== 1'b0) begin errors++; $display("FAIL sb_fwd_stall: stall=%b want 0", iss_stall); end
        tick(); iss_valid = 0; #1;
        checks++;
        if (q_busy1 !== 1'b1) begin errors++; $display("FAIL sb_set_wins: q_busy1=%b want 1", q_busy1); end
        flush = 1; tick(); flush = 0;
    endtask

    task automatic test_x0();
        s1_valid = 1; s1_rd = 0; s1_data = 32'h1234; q_addr2 = 0; #1;
        checks++;
        if (s1_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: s1_ready=%b want 1", s1_ready); end
        tick(); s1_valid = 0;
        iss_valid = 1; iss_rd = 0;
        checks++;
        if (we !== 1'b0 || q_busy2 !== 1'b0) begin
            errors++; $display("FAIL x0_wb: we=%b q_busy2=%b want 0/0", we, q_busy2);
        end
        tick(); iss_valid = 0; #1;
        checks++;
        if (q_busy2 !== 1'b0 || iss_stall !== 1'b0) begin
            errors++; $display("FAIL x0_claim: q_busy2=%b stall=%b want 0/0", q_busy2, iss_stall);
        end
    endtask

    task automatic test_flush();
        iss_valid = 1; iss_rd = 3; tick();
        iss_rd = 9; tick(); iss_valid = 0;
        s0_valid = 1; s0_rd = 3; s0_data = 32'h33; tick(); s0_valid = 0;
        flush = 1; iss_valid = 1; iss_rd = 4;
        s1_valid = 1; s1_rd = 12; s1_data = 32'hC12; #1;
        checks++;
        if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33 || s1_ready !== 1'b1) begin
            errors++; $display("FAIL flush_inflight: we=%b waddr=%0d wdata=%h s1_ready=%b want 1/3/33/1",
                               we, waddr, wdata, s1_ready);
        end
        tick(); idle_inputs();
        checks++;
        if (we !== 1'b1 || waddr !== 5'd12 || wdata !== 32'hC12) begin
            errors++; $display("FAIL flush_accepted: we=%b waddr=%0d wdata=%h want 1/12/c12", we, waddr, wdata);
        end
        tick();
        for (int a = 0; a < 32; a++) begin
            q_addr1 = a[4:0]; #1;
            checks++;
            if (q_busy1 !== 1'b0) begin errors++; $display("FAIL flush_busy%0d: got %b want 0", a, q_busy1); end
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        s0_valid = 1; s0_rd = 2; s0_data = 32'h22; iss_valid = 1; iss_rd = 2;
        tick(); idle_inputs();
        #2 rst_n = 0; #1;
        model_reset();
        checks++;
        if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0) begin
            errors++; $display("FAIL midrst_we: we=%b waddr=%0d wdata=%h want 0/0/0", we, waddr, wdata);
        end
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (we !== 1'b0) begin errors++; $display("FAIL midrst_after%0d: we=%b want 0", i, we); end
        end
        q_addr1 = 2; #1;
        checks++;
        if (q_busy1 !== 1'b0) begin errors++; $display("FAIL midrst_pend: q_busy1=%b want 0", q_busy1); end
    endtask

    task automatic test_random();
        bit [1:0] g;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            g = model_grant();
            if (!(s0_valid && !g[0])) begin
                s0_valid = ($urandom_range(0, 2) != 0); s0_rd = 5'($urandom); s0_data = $urandom;
            end
            if (!(s1_valid && !g[1])) begin
                s1_valid = ($urandom_range(0, 2) != 0); s1_rd = 5'($urandom); s1_data = $urandom;
            end
            iss_valid = $urandom_range(0, 1); iss_rd = 5'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            q_addr1 = ($urandom_range(0, 1) != 0) ? m_waddr : 5'($urandom);
            q_addr2 = 5'($urandom);
            #1;
            g = model_grant();
            checks++;
            if (s0_ready !== g[0] || s1_ready !== g[1]) begin
                errors++; $display("FAIL rnd_grant c%0d: ready s0/s1=%b%b want %b%b", c, s0_ready, s1_ready, g[0], g[1]);
            end
            checks++;
            if (iss_stall !== (iss_valid && exp_busy(iss_rd)) || q_busy1 !== exp_busy(q_addr1)
                || q_busy2 !== exp_busy(q_addr2)) begin
                errors++; $display("FAIL rnd_sb c%0d: stall/b1/b2=%b%b%b want %b%b%b", c, iss_stall, q_busy1, q_busy2,
                                   iss_valid && exp_busy(iss_rd), exp_busy(q_addr1), exp_busy(q_addr2));
            end
            tick();
            checks++;
            if (we !== m_we || (m_we && (waddr !== m_waddr || wdata !== m_wdata))) begin
                errors++; $display("FAIL rnd_wb c%0d: we=%b waddr=%0d wdata=%h want %b/%0d/%h",
                                   c, we, waddr, wdata, m_we, m_waddr, m_wdata);
            end
        end
        idle_inputs(); tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_scoreboard();
        test_x0();
        test_flush();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
